// File: rtl/kickstart_multirom_pkg.sv
// Shared types and constants for the multi-image kickstart controller.
// Also holds the autoconfig size-code helper.
package kickstart_multirom_pkg;

    typedef enum logic [2:0] {IDLE, DECODE, WAIT, ACK, PASS, END} busState_t;

    localparam logic [7:0] AC_OFF_BASE_HI = 8'h48;
    localparam logic [7:0] AC_OFF_BASE_LO = 8'h4A;
    localparam logic [7:0] AC_OFF_SHUTUP  = 8'h4C;

    localparam logic [7:0] CIA_RANGE        = 8'hBF;
    localparam logic [7:0] AUTOCONFIG_RANGE = 8'hE8;
    localparam logic [4:0] KICK_RANGE       = 5'h1F;

    // Zorro II size code for a board of 512K << l bytes.
    function automatic logic [2:0] sizeCode(input int l);
        return 3'b100 + 3'(l);
    endfunction

endpackage

// File: rtl/kickstart_multirom_ctrl_nibble_rom.sv
// Autoconfig read-back ROM: byte offset in, registered D15:12 nibble out.
// Only the first two nibbles are stored true; the rest are inverted.
module autoconfig_nibble_rom
    import kickstart_multirom_pkg::*;
#(
    parameter int          ROM_L           = 1,
    parameter logic [15:0] MANUFACTURER_ID = 16'h07B9,
    parameter logic [7:0]  PRODUCT_ID      = 8'd104,
    parameter logic [31:0] SERIAL          = 32'h00000400
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       load,
    input  logic [7:0] offset,
    output logic [3:0] nibble
);

    localparam logic [2:0] SIZE_CODE = sizeCode(ROM_L);

    logic [3:0] romValue;

    // NOTE: every path assigns romValue, so unlisted offsets cannot infer a latch.
    always_comb begin
        romValue = 4'hF;
        case (offset)
            8'h00:   romValue = 4'b1100;
            8'h02:   romValue = {1'b0, SIZE_CODE};
            8'h04:   romValue = ~PRODUCT_ID[7:4];
            8'h06:   romValue = ~PRODUCT_ID[3:0];
            8'h08:   romValue = ~4'b1000;
            8'h10:   romValue = ~MANUFACTURER_ID[15:12];
            8'h12:   romValue = ~MANUFACTURER_ID[11:8];
            8'h14:   romValue = ~MANUFACTURER_ID[7:4];
            8'h16:   romValue = ~MANUFACTURER_ID[3:0];
            8'h18:   romValue = ~SERIAL[31:28];
            8'h1A:   romValue = ~SERIAL[27:24];
            8'h1C:   romValue = ~SERIAL[23:20];
            8'h1E:   romValue = ~SERIAL[19:16];
            8'h20:   romValue = ~SERIAL[15:12];
            8'h22:   romValue = ~SERIAL[11:8];
            8'h24:   romValue = ~SERIAL[7:4];
            8'h26:   romValue = ~SERIAL[3:0];
            default: romValue = 4'hF;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            nibble <= 4'hF;
        end else if (load) begin
            nibble <= romValue;
        end
    end

endmodule

// File: rtl/kickstart_multirom_ctrl.sv
// Kickstart selector between the 68000 socket and the motherboard: serves ROM space
// from one of NUM_ROMS flash images, or exposes all images as a Zorro II board.
module kickstart_multirom_ctrl
    import kickstart_multirom_pkg::*;
#(
    parameter int          NUM_ROMS           = 2,
    parameter int          BOOT_SEL           = 0,
    parameter int          SWITCH_HOLD_CYCLES = 7093790,
    parameter int          WAIT_STATES        = 1,
    parameter logic [15:0] MANUFACTURER_ID    = 16'h07B9,
    parameter logic [7:0]  PRODUCT_ID         = 8'd104,
    parameter logic [31:0] SERIAL             = 32'h00000400
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BUS_RESET_n,
    input  logic       CPU_AS_n,
    input  logic       UDS_n,
    input  logic       LDS_n,
    input  logic       RW,
    input  logic [7:0] ADDRESS_HIGH,
    input  logic [6:0] ADDRESS_LOW,
    input  logic [3:0] DATA_IN,
    output logic [3:0] DATA_OUT,
    output logic       DATA_OE,
    output logic       MB_AS_n,
    output logic       DTACK_n,
    output logic       DTACK_OE,
    output logic [1:0] FLASH_RD_n,
    output logic [1:0] FLASH_WR_n,
    output logic [((NUM_ROMS > 1) ? $clog2(NUM_ROMS) : 1)-1:0] FLASH_BANK,
    output logic [2:0] ROM_SEL
);

    localparam int L       = $clog2(NUM_ROMS);
    localparam int BANK_W  = (L > 0) ? L : 1;
    localparam int HOLD_W  = $clog2(SWITCH_HOLD_CYCLES + 1);
    localparam int WAIT_W  = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(SWITCH_HOLD_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    logic [1:0] asSyncR, udsSyncR, ldsSyncR, rwSyncR, busRstSyncR;
    logic       asSync, udsSync, ldsSync, rwSync, busRstSync;

    busState_t         state;
    logic [WAIT_W-1:0] waitCnt;
    logic [HOLD_W-1:0] holdCnt;
    logic [2:0]        sel, selMinusOne;
    logic [7:0]        base, latchHigh, latchOffset;
    logic [3:0]        dataLatch;
    logic              overlay, configured, baseValid;
    logic              latchRw, latchAc, latchHit, cycleOk;
    logic              dtackOe, dtackN, dataOe;
    logic              kick, ovl, ac, win, hit, flashMode, flashRdEn, flashWrEn;
    logic [BANK_W-1:0] winBank;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            asSyncR     <= 2'b11;
            udsSyncR    <= 2'b11;
            ldsSyncR    <= 2'b11;
            rwSyncR     <= 2'b11;
            busRstSyncR <= 2'b11;
        end else begin
            asSyncR     <= {asSyncR[0], CPU_AS_n};
            udsSyncR    <= {udsSyncR[0], UDS_n};
            ldsSyncR    <= {ldsSyncR[0], LDS_n};
            rwSyncR     <= {rwSyncR[0], RW};
            busRstSyncR <= {busRstSyncR[0], BUS_RESET_n};
        end
    end

    assign asSync     = asSyncR[1];
    assign udsSync    = udsSyncR[1];
    assign ldsSync    = ldsSyncR[1];
    assign rwSync     = rwSyncR[1];
    assign busRstSync = busRstSyncR[1];

    // Decode works on the raw bus so the motherboard sees AS without added latency.
    always_comb begin
        kick      = ADDRESS_HIGH[7:3] == KICK_RANGE;
        ovl       = overlay && (ADDRESS_HIGH[7:3] == 5'h00);
        ac        = ADDRESS_HIGH == AUTOCONFIG_RANGE;
        win       = baseValid && (ADDRESS_HIGH[7:3+L] == base[7:3+L]);
        flashMode = sel != 3'd0;
        hit       = flashMode ? (kick || ovl) : ((ac && !configured) || win);
    end

    generate
        if (L == 0) begin : gSingleImage
            assign winBank = '0;
        end else begin : gMultiImage
            assign winBank = ADDRESS_HIGH[2+L:3];
        end
    endgenerate

    assign selMinusOne = sel - 3'd1;
    assign flashRdEn   = !RESET && !CPU_AS_n && RW && ((flashMode && hit) || win);
    assign flashWrEn   = !RESET && !CPU_AS_n && !RW && win;
    assign MB_AS_n     = CPU_AS_n || hit || RESET;
    assign FLASH_RD_n  = flashRdEn ? {UDS_n, LDS_n} : 2'b11;
    assign FLASH_WR_n  = flashWrEn ? {UDS_n, LDS_n} : 2'b11;
    assign FLASH_BANK  = flashMode ? selMinusOne[BANK_W-1:0] : (win ? winBank : '0);
    assign ROM_SEL     = sel;
    assign DTACK_OE    = dtackOe;
    assign DTACK_n     = dtackN;
    assign DATA_OE     = dataOe;

    // A long bus-reset hold steps the selection once; releasing clears the count.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sel     <= 3'(BOOT_SEL);
            holdCnt <= '0;
        end else if (busRstSync) begin
            holdCnt <= '0;
        end else if (holdCnt != HOLD_MAX) begin
            holdCnt <= holdCnt + HOLD_W'(1);
            if (holdCnt == HOLD_MAX - HOLD_W'(1)) begin
                sel <= (sel == 3'(NUM_ROMS)) ? 3'd0 : sel + 3'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            waitCnt     <= '0;
            overlay     <= 1'b1;
            configured  <= 1'b0;
            baseValid   <= 1'b0;
            base        <= 8'h00;
            latchHigh   <= 8'h00;
            latchOffset <= 8'h00;
            latchRw     <= 1'b1;
            latchAc     <= 1'b0;
            latchHit    <= 1'b0;
            cycleOk     <= 1'b0;
            dataLatch   <= 4'h0;
            dtackOe     <= 1'b0;
            dtackN      <= 1'b1;
            dataOe      <= 1'b0;
        end else if (!busRstSync) begin
            state      <= IDLE;
            overlay    <= 1'b1;
            configured <= 1'b0;
            baseValid  <= 1'b0;
            dtackOe    <= 1'b0;
            dtackN     <= 1'b1;
            dataOe     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cycleOk <= 1'b0;
                    if (!asSync) state <= DECODE;
                end
                DECODE: begin
                    latchHigh   <= ADDRESS_HIGH;
                    latchOffset <= {ADDRESS_LOW, 1'b0};
                    latchRw     <= rwSync;
                    latchAc     <= ac;
                    latchHit    <= hit;
                    waitCnt     <= '0;
                    if (hit) begin
                        dataOe <= ac && rwSync;
                        if (WAIT_STATES == 0) begin
                            state   <= ACK;
                            dtackOe <= 1'b1;
                            dtackN  <= 1'b0;
                            cycleOk <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end else begin
                        state   <= PASS;
                        cycleOk <= 1'b1;
                    end
                end
                WAIT: begin
                    if (asSync) begin
                        state  <= END;
                        dataOe <= 1'b0;
                    end else if (waitCnt == WAIT_LAST) begin
                        state   <= ACK;
                        dtackOe <= 1'b1;
                        dtackN  <= 1'b0;
                        cycleOk <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + WAIT_W'(1);
                    end
                end
                ACK: begin
                    if (!udsSync || !ldsSync) dataLatch <= DATA_IN;
                    if (asSync) begin
                        state   <= END;
                        dtackOe <= 1'b0;
                        dtackN  <= 1'b1;
                        dataOe  <= 1'b0;
                    end
                end
                PASS: begin
                    if (asSync) state <= END;
                end
                END: begin
                    state  <= IDLE;
                    dataOe <= 1'b0;
                    if (cycleOk && latchHit && latchAc && !latchRw) begin
                        case (latchOffset)
                            AC_OFF_BASE_LO: base[3:0] <= dataLatch;
                            AC_OFF_BASE_HI: begin
                                base[7:4]  <= dataLatch;
                                baseValid  <= 1'b1;
                                configured <= 1'b1;
                            end
                            AC_OFF_SHUTUP: configured <= 1'b1;
                            default: ;
                        endcase
                    end
                    if (cycleOk && latchHigh == CIA_RANGE) overlay <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    autoconfig_nibble_rom #(
        .ROM_L          (L),
        .MANUFACTURER_ID(MANUFACTURER_ID),
        .PRODUCT_ID     (PRODUCT_ID),
        .SERIAL         (SERIAL)
    ) nibbleRom (
        .CLK   (CLK),
        .RESET (RESET),
        .load  (state == DECODE),
        .offset({ADDRESS_LOW, 1'b0}),
        .nibble(DATA_OUT)
    );

endmodule

// File: tb/tb_kickstart_multirom_ctrl.sv
// Directed bench for kickstart_multirom_ctrl with two images, short switch hold.
// Each task drives one scenario and compares against hand-derived values.
module tb_kickstart_multirom_ctrl;

    localparam int NUM_ROMS    = 2;
    localparam int BOOT_SEL    = 0;
    localparam int HOLD        = 20;
    localparam int WS          = 2;
    // Negedges from raw AS assertion until DTACK is visible: 2 sync + DECODE + WAIT_STATES + 1.
    localparam int ACK_LATENCY = WS + 4;

    logic       CLK = 1'b0;
    logic       RESET, BUS_RESET_n, CPU_AS_n, UDS_n, LDS_n, RW;
    logic [7:0] ADDRESS_HIGH;
    logic [6:0] ADDRESS_LOW;
    logic [3:0] DATA_IN, DATA_OUT;
    logic       DATA_OE, MB_AS_n, DTACK_n, DTACK_OE;
    logic [1:0] FLASH_RD_n, FLASH_WR_n;
    logic [0:0] FLASH_BANK;
    logic [2:0] ROM_SEL;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    kickstart_multirom_ctrl #(
        .NUM_ROMS          (NUM_ROMS),
        .BOOT_SEL          (BOOT_SEL),
        .SWITCH_HOLD_CYCLES(HOLD),
        .WAIT_STATES       (WS)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .BUS_RESET_n (BUS_RESET_n),
        .CPU_AS_n    (CPU_AS_n),
        .UDS_n       (UDS_n),
        .LDS_n       (LDS_n),
        .RW          (RW),
        .ADDRESS_HIGH(ADDRESS_HIGH),
        .ADDRESS_LOW (ADDRESS_LOW),
        .DATA_IN     (DATA_IN),
        .DATA_OUT    (DATA_OUT),
        .DATA_OE     (DATA_OE),
        .MB_AS_n     (MB_AS_n),
        .DTACK_n     (DTACK_n),
        .DTACK_OE    (DTACK_OE),
        .FLASH_RD_n  (FLASH_RD_n),
        .FLASH_WR_n  (FLASH_WR_n),
        .FLASH_BANK  (FLASH_BANK),
        .ROM_SEL     (ROM_SEL)
    );

    task automatic startCycle(input logic [23:0] addr, input logic rw, input logic [3:0] nib);
        ADDRESS_HIGH = addr[23:16];
        ADDRESS_LOW  = addr[7:1];
        RW           = rw;
        DATA_IN      = nib;
        CPU_AS_n     = 1'b0;
        UDS_n        = 1'b0;
        LDS_n        = 1'b0;
        #1;
    endtask

    task automatic endCycle();
        CPU_AS_n = 1'b1;
        UDS_n    = 1'b1;
        LDS_n    = 1'b1;
        repeat (6) @(negedge CLK);
    endtask

    task automatic waitDtack(input int budget, output bit got, output int cycles);
        got    = 1'b0;
        cycles = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge CLK);
            if (DTACK_OE === 1'b1 && DTACK_n === 1'b0) begin
                got    = 1'b1;
                cycles = i;
                break;
            end
        end
    endtask

    task automatic busReset(input int lowCycles);
        BUS_RESET_n = 1'b0;
        repeat (lowCycles) @(negedge CLK);
        BUS_RESET_n = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        checks++; if (DTACK_OE !== 1'b0) begin errors++; $display("FAIL reset_dtack_oe: got %b want 0", DTACK_OE); end
        checks++; if (DATA_OE !== 1'b0) begin errors++; $display("FAIL reset_data_oe: got %b want 0", DATA_OE); end
        checks++; if (FLASH_RD_n !== 2'b11) begin errors++; $display("FAIL reset_flash_rd: got %b want 11", FLASH_RD_n); end
        checks++; if (FLASH_WR_n !== 2'b11) begin errors++; $display("FAIL reset_flash_wr: got %b want 11", FLASH_WR_n); end
        checks++; if (MB_AS_n !== 1'b1) begin errors++; $display("FAIL reset_mb_as: got %b want 1", MB_AS_n); end
        checks++; if (ROM_SEL !== 3'(BOOT_SEL)) begin errors++; $display("FAIL reset_rom_sel: got %0d want %0d", ROM_SEL, BOOT_SEL); end
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_autoconfig_read();
        logic [23:0] addrs [5] = '{24'hE80002, 24'hE80000, 24'hE80004, 24'hE80012, 24'hE80022};
        logic [3:0]  nibs  [5] = '{4'b0101, 4'b1100, 4'h9, 4'h8, 4'hB};
        bit got;
        int cyc;
        for (int i = 0; i < 5; i++) begin
            startCycle(addrs[i], 1'b1, 4'h0);
            waitDtack(20, got, cyc);
            checks++; if (!got) begin errors++; $display("FAIL ac_read_dtack[%0d]: no DTACK within 20 cycles", i); end
            if (i == 0) begin
                checks++; if (cyc != ACK_LATENCY) begin errors++; $display("FAIL ac_read_latency: got %0d want %0d", cyc, ACK_LATENCY); end
            end
            checks++; if (DATA_OE !== 1'b1) begin errors++; $display("FAIL ac_read_oe[%0d]: got %b want 1", i, DATA_OE); end
            checks++; if (DATA_OUT !== nibs[i]) begin errors++; $display("FAIL ac_read_nibble[%h]: got %b want %b", addrs[i], DATA_OUT, nibs[i]); end
            checks++; if (MB_AS_n !== 1'b1) begin errors++; $display("FAIL ac_read_mb_as[%0d]: got %b want 1", i, MB_AS_n); end
            endCycle();
        end
    endtask

    task automatic test_abort();
        bit sawDtack = 1'b0;
        bit got;
        int cyc;
        startCycle(24'hE80048, 1'b0, 4'h2);
        repeat (2) @(negedge CLK);
        CPU_AS_n = 1'b1;
        UDS_n    = 1'b1;
        LDS_n    = 1'b1;
        repeat (10) begin
            @(negedge CLK);
            if (DTACK_OE !== 1'b0) sawDtack = 1'b1;
        end
        checks++; if (sawDtack) begin errors++; $display("FAIL abort_no_dtack: DTACK_OE seen 1, want 0 throughout"); end
        // Still unconfigured: autoconfig space must keep answering locally.
        startCycle(24'hE80000, 1'b1, 4'h0);
        checks++; if (MB_AS_n !== 1'b1) begin errors++; $display("FAIL abort_still_unconfigured: MB_AS_n got %b want 1", MB_AS_n); end
        waitDtack(20, got, cyc);
        checks++; if (!got) begin errors++; $display("FAIL abort_followup_dtack: no DTACK within 20 cycles"); end
        endCycle();
    endtask

    task automatic test_configure();
        bit got;
        int cyc;
        startCycle(24'hE8004A, 1'b0, 4'h0);
        waitDtack(20, got, cyc);
        checks++; if (!got) begin errors++; $display("FAIL cfg_write_lo_dtack: no DTACK"); end
        endCycle();
        startCycle(24'hE80048, 1'b0, 4'h2);
        checks++; if (FLASH_WR_n !== 2'b11) begin errors++; $display("FAIL cfg_write_hi_flash_wr: got %b want 11", FLASH_WR_n); end
        waitDtack(20, got, cyc);
        checks++; if (!got) begin errors++; $display("FAIL cfg_write_hi_dtack: no DTACK"); end
        endCycle();

        startCycle(24'h280000, 1'b1, 4'h0);
        checks++; if (FLASH_RD_n !== 2'b00) begin errors++; $display("FAIL win_read_rd: got %b want 00", FLASH_RD_n); end
        checks++; if (FLASH_BANK !== 1'b1) begin errors++; $display("FAIL win_read_bank: got %b want 1", FLASH_BANK); end
        checks++; if (MB_AS_n !== 1'b1) begin errors++; $display("FAIL win_read_mb_as: got %b want 1", MB_AS_n); end
        waitDtack(20, got, cyc);
        checks++; if (!got) begin errors++; $display("FAIL win_read_dtack: no DTACK"); end
        endCycle();

        startCycle(24'h200000, 1'b0, 4'h5);
        checks++; if (FLASH_WR_n !== 2'b00) begin errors++; $display("FAIL win_write_wr: got %b want 00", FLASH_WR_n); end
        checks++; if (FLASH_BANK !== 1'b0) begin errors++; $display("FAIL win_write_bank: got %b want 0", FLASH_BANK); end
        checks++; if (FLASH_RD_n !== 2'b11) begin errors++; $display("FAIL win_write_rd: got %b want 11", FLASH_RD_n); end
        waitDtack(20, got, cyc);
        endCycle();

        startCycle(24'hE80000, 1'b1, 4'h0);
        checks++; if (MB_AS_n !== 1'b0) begin errors++; $display("FAIL configured_ac_to_mb: MB_AS_n got %b want 0", MB_AS_n); end
        waitDtack(12, got, cyc);
        checks++; if (got) begin errors++; $display("FAIL configured_ac_no_dtack: DTACK seen, want none"); end
        endCycle();
    endtask

    task automatic test_switch();
        bit badOe = 1'b0;
        bit got;
        int cyc;
        BUS_RESET_n = 1'b0;
        repeat (HOLD / 2) begin
            @(negedge CLK);
            if (DTACK_OE !== 1'b0 || DATA_OE !== 1'b0) badOe = 1'b1;
        end
        checks++; if (ROM_SEL !== 3'd0) begin errors++; $display("FAIL switch_early: ROM_SEL got %0d want 0", ROM_SEL); end
        repeat (HOLD / 2 + 100) begin
            @(negedge CLK);
            if (DTACK_OE !== 1'b0 || DATA_OE !== 1'b0) badOe = 1'b1;
        end
        checks++; if (ROM_SEL !== 3'd1) begin errors++; $display("FAIL switch_once: ROM_SEL got %0d want 1", ROM_SEL); end
        checks++; if (badOe) begin errors++; $display("FAIL switch_oe_quiet: DTACK_OE/DATA_OE seen 1 during bus reset, want 0"); end
        BUS_RESET_n = 1'b1;
        repeat (4) @(negedge CLK);
        checks++; if (ROM_SEL !== 3'd1) begin errors++; $display("FAIL switch_after_release: ROM_SEL got %0d want 1", ROM_SEL); end

        startCycle(24'h000004, 1'b1, 4'h0);
        checks++; if (FLASH_RD_n !== 2'b00) begin errors++; $display("FAIL ovl_read_rd: got %b want 00", FLASH_RD_n); end
        checks++; if (FLASH_BANK !== 1'b0) begin errors++; $display("FAIL ovl_read_bank: got %b want 0", FLASH_BANK); end
        checks++; if (MB_AS_n !== 1'b1) begin errors++; $display("FAIL ovl_read_mb_as: got %b want 1", MB_AS_n); end
        waitDtack(20, got, cyc);
        checks++; if (!got) begin errors++; $display("FAIL ovl_read_dtack: no DTACK"); end
        endCycle();
    endtask

    task automatic test_flash_write();
        bit got;
        int cyc;
        startCycle(24'hF80000, 1'b0, 4'hA);
        checks++; if (FLASH_WR_n !== 2'b11) begin errors++; $display("FAIL kick_write_wr: got %b want 11", FLASH_WR_n); end
        checks++; if (MB_AS_n !== 1'b1) begin errors++; $display("FAIL kick_write_mb_as: got %b want 1", MB_AS_n); end
        waitDtack(20, got, cyc);
        checks++; if (!got) begin errors++; $display("FAIL kick_write_dtack: no DTACK"); end
        checks++; if (FLASH_WR_n !== 2'b11) begin errors++; $display("FAIL kick_write_wr_ack: got %b want 11", FLASH_WR_n); end
        endCycle();
    endtask

    task automatic test_overlay_clear();
        bit got;
        int cyc;
        startCycle(24'hBFE001, 1'b1, 4'h0);
        checks++; if (MB_AS_n !== 1'b0) begin errors++; $display("FAIL cia_read_mb_as: got %b want 0", MB_AS_n); end
        waitDtack(12, got, cyc);
        checks++; if (got) begin errors++; $display("FAIL cia_read_no_dtack: DTACK seen, want none"); end
        endCycle();
        startCycle(24'h000004, 1'b1, 4'h0);
        checks++; if (MB_AS_n !== 1'b0) begin errors++; $display("FAIL post_ovl_mb_as: got %b want 0", MB_AS_n); end
        checks++; if (FLASH_RD_n !== 2'b11) begin errors++; $display("FAIL post_ovl_rd: got %b want 11", FLASH_RD_n); end
        endCycle();
    endtask

    task automatic test_selection_cycle();
        logic [2:0] expSel [3] = '{3'd1, 3'd2, 3'd0};
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        checks++; if (ROM_SEL !== 3'd0) begin errors++; $display("FAIL cycle_start: ROM_SEL got %0d want 0", ROM_SEL); end
        for (int i = 0; i < 3; i++) begin
            busReset(HOLD + 10);
            checks++; if (ROM_SEL !== expSel[i]) begin errors++; $display("FAIL cycle_step[%0d]: ROM_SEL got %0d want %0d", i, ROM_SEL, expSel[i]); end
        end
        // One cycle short of the hold, twice: the count must not carry over.
        busReset(HOLD - 1);
        busReset(HOLD - 1);
        checks++; if (ROM_SEL !== 3'd0) begin errors++; $display("FAIL short_hold: ROM_SEL got %0d want 0", ROM_SEL); end
        busReset(HOLD);
        checks++; if (ROM_SEL !== 3'd1) begin errors++; $display("FAIL exact_hold: ROM_SEL got %0d want 1", ROM_SEL); end
    endtask

    task automatic test_reset_midcycle();
        bit got;
        int cyc;
        startCycle(24'hF80000, 1'b1, 4'h0);
        waitDtack(20, got, cyc);
        checks++; if (!got) begin errors++; $display("FAIL midreset_dtack: no DTACK before reset"); end
        RESET = 1'b1;
        @(negedge CLK);
        checks++; if (DTACK_OE !== 1'b0) begin errors++; $display("FAIL midreset_dtack_oe: got %b want 0", DTACK_OE); end
        checks++; if (DTACK_n !== 1'b1) begin errors++; $display("FAIL midreset_dtack_n: got %b want 1", DTACK_n); end
        checks++; if (FLASH_RD_n !== 2'b11) begin errors++; $display("FAIL midreset_rd: got %b want 11", FLASH_RD_n); end
        checks++; if (MB_AS_n !== 1'b1) begin errors++; $display("FAIL midreset_mb_as: got %b want 1", MB_AS_n); end
        checks++; if (ROM_SEL !== 3'(BOOT_SEL)) begin errors++; $display("FAIL midreset_sel: got %0d want %0d", ROM_SEL, BOOT_SEL); end
        CPU_AS_n = 1'b1;
        UDS_n    = 1'b1;
        LDS_n    = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        RESET        = 1'b1;
        BUS_RESET_n  = 1'b1;
        CPU_AS_n     = 1'b1;
        UDS_n        = 1'b1;
        LDS_n        = 1'b1;
        RW           = 1'b1;
        ADDRESS_HIGH = 8'h00;
        ADDRESS_LOW  = 7'h00;
        DATA_IN      = 4'h0;
        @(negedge CLK);
        test_reset();
        test_autoconfig_read();
        test_abort();
        test_configure();
        test_switch();
        test_flash_write();
        test_overlay_clear();
        test_selection_cycle();
        test_reset_midcycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
